dcsk_correlator: RTL and testbench
==================================

DCSK_CORRELATOR -- requirements
Module: dcsk_correlator

Interface
REQ-001 Parameter WORD_LEN, 8, operand width of the upstream Booth multiplier; product width is 2*WORD_LEN.
REQ-002 Parameter SPREAD_FACTOR, 16, chips per bit (beta); legal range is 2 or more.
REQ-003 Parameter ACC_W, 2*WORD_LEN+$clog2(SPREAD_FACTOR), accumulator width; legal range is 2*WORD_LEN or more.
REQ-004 Port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port i_arst_n, input, 1, reset; asynchronous, active-low.
REQ-006 Port i_product, input, 2*WORD_LEN signed, chip product from the Booth multiplier.
REQ-007 Port i_valid, input, 1, i_product is valid this cycle.
REQ-008 Port o_ready, output, 1, block accepts i_product this cycle.
REQ-009 Port i_clear, input, 1, synchronous abort of the current symbol.
REQ-010 Port o_sum, output, ACC_W signed, correlation sum of the completed symbol.
REQ-011 Port o_bit, output, 1, demodulated bit.
REQ-012 Port o_valid, output, 1, o_sum/o_bit/o_sat valid.
REQ-013 Port i_ready, input, 1, downstream accepts the result.
REQ-014 Port o_sat, output, 1, saturation occurred during the symbol.

Function
REQ-015 Transfer in: a product is accepted in any cycle with i_valid=1 and o_ready=1.
REQ-016 Transfer out: a result is consumed in any cycle with o_valid=1 and i_ready=1.
REQ-017 FSM states: IDLE, ACCUM, DONE.
REQ-018 o_ready: 1 in IDLE and ACCUM, 0 in DONE.
REQ-019 o_valid: 1 only in DONE.
REQ-020 IDLE: on an accepted product, acc <= sign-extended product, count <= 1, next state ACCUM.
REQ-021 ACCUM: each accepted product adds its sign-extended value to acc and increments count; cycles with i_valid=0 hold state.
REQ-022 ACCUM: the accepted product with count == SPREAD_FACTOR-1 completes the symbol; next state DONE.
REQ-023 Latency: o_valid rises on the first clock edge after the last accepted product of the symbol.
REQ-024 DONE: o_sum, o_bit and o_sat hold stable until consumed; products offered with o_ready=0 are not accepted and have no effect.
REQ-025 DONE: on a consumed result, next state IDLE with acc and count cleared.
REQ-026 o_bit = NOT o_sum[ACC_W-1]; a zero sum gives o_bit=1.
REQ-027 Without saturation, the sum wraps modulo 2^ACC_W.
REQ-028 i_clear has highest priority in every state: next cycle is IDLE with acc=0, count=0, o_sat=0, and o_valid=0; any product offered in the same cycle is dropped.

Reset
REQ-029 While i_arst_n=0: state is IDLE; acc, count, o_sum, o_bit and o_sat are 0; o_valid=0; o_ready=1.
REQ-030 Reset asserted mid-symbol discards the partial sum with no output.

Configuration
REQ-031 Macro DCSK_CORR_SAT_EN defined: each addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and o_sat is a sticky flag for the symbol.
REQ-032 Macro DCSK_CORR_SAT_EN undefined: wrapping add applies and o_sat is tied to 0.

Structure
REQ-033 Package dcsk_pkg holds the FSM state enum typedef and the default WORD_LEN and SPREAD_FACTOR constants shared with booth_mul.
REQ-034 Sub-module dcsk_sat_add implements the ACC_W adder, with optional clamp and an overflow flag, under DCSK_CORR_SAT_EN.

Verification (WORD_LEN=8, SPREAD_FACTOR=4, default ACC_W=18 unless noted)
REQ-035 Basic: products 100, 200, -50, 10 on consecutive cycles -> o_valid on the next edge, o_sum=260, o_bit=1.
REQ-036 Negative: four products of -16256 -> o_sum=-65024, o_bit=0, o_sat=0.
REQ-037 Backpressure: i_ready=0 for 5 cycles in DONE while i_valid=1 with product 999 -> o_sum holds 260, o_ready=0, and the next symbol is unaffected by 999.
REQ-038 Abort: i_clear after two products (100, 200), then products 1, 2, 3, 4 -> o_sum=10; i_clear asserted in DONE drops o_valid the next cycle.
REQ-039 Reset: i_arst_n pulsed low after three products -> all outputs 0 immediately; a following symbol of products 5, 5, 5, 5 -> o_sum=20.
REQ-040 Saturation (ACC_W=16): four products of 16129 -> with DCSK_CORR_SAT_EN, o_sum=32767, o_sat=1, o_bit=1; without it, o_sum=-1020, o_bit=0, o_sat=0.

Source files
------------

// File: rtl/dcsk_correlator_pkg.sv
// Shared definitions for the DCSK correlator: FSM state type and the default
// operand / spreading constants also used by booth_mul.
package dcsk_pkg;

   localparam int WORD_LEN_DEF      = 8;
   localparam int SPREAD_FACTOR_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

endpackage

// File: rtl/dcsk_correlator_sat_add.sv
// Signed W-bit adder for the correlator accumulator.
// With DCSK_CORR_SAT_EN defined it clamps to the signed range and flags overflow.
module dcsk_sat_add #(
   parameter int W = 18
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
`ifdef DCSK_CORR_SAT_EN
   output logic                ovf,
`endif
   output logic signed [W-1:0] sum
);

`ifdef DCSK_CORR_SAT_EN
   logic signed [W:0] full;

   assign full = {a[W-1], a} + {b[W-1], b};
   // The two top bits disagree exactly when the W-bit result would wrap.
   assign ovf  = full[W] ^ full[W-1];
   assign sum  = ovf ? (full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                     : full[W-1:0];
`else
   assign sum = a + b;
`endif

endmodule

// File: rtl/dcsk_correlator.sv
// DCSK symbol correlator: accumulates SPREAD_FACTOR chip products per symbol
// and emits the sum and its sign as the demodulated bit. Saturating mode: DCSK_CORR_SAT_EN.
module dcsk_correlator
   import dcsk_pkg::*;
#(
   parameter int WORD_LEN      = WORD_LEN_DEF,
   parameter int SPREAD_FACTOR = SPREAD_FACTOR_DEF,
   parameter int ACC_W         = 2*WORD_LEN + $clog2(SPREAD_FACTOR)
) (
   input  logic                      i_clk,
   input  logic                      i_arst_n,
   input  logic signed [2*WORD_LEN-1:0] i_product,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic                      i_clear,
   output logic signed [ACC_W-1:0]   o_sum,
   output logic                      o_bit,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_sat
);

   localparam int CNT_W = $clog2(SPREAD_FACTOR) + 1;

   state_t                   state, state_nx;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  base;
   logic signed [ACC_W-1:0]  add_sum;
   logic [CNT_W-1:0]         count;
   logic                     bit_q;
   logic                     accept;
   logic                     last;
   logic                     consume;

   assign prod_ext = ACC_W'(i_product);
   // The first chip of a symbol starts from zero rather than the stale accumulator.
   assign base     = (state == ACCUM) ? acc : '0;

`ifdef DCSK_CORR_SAT_EN
   logic ovf;
   logic sat;

   dcsk_sat_add #(.W(ACC_W)) u_add (
      .a   (base),
      .b   (prod_ext),
      .ovf (ovf),
      .sum (add_sum)
   );

   assign o_sat = sat;
`else
   dcsk_sat_add #(.W(ACC_W)) u_add (
      .a   (base),
      .b   (prod_ext),
      .sum (add_sum)
   );

   assign o_sat = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      consume  = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid) begin
               accept   = 1'b1;
               state_nx = ACCUM;
            end
         end
         ACCUM: begin
            if (i_valid) begin
               accept = 1'b1;
               if (count == CNT_W'(SPREAD_FACTOR - 1)) begin
                  last     = 1'b1;
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            if (i_ready) begin
               consume  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (i_clear) begin
         accept   = 1'b0;
         last     = 1'b0;
         state_nx = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         bit_q <= 1'b0;
`ifdef DCSK_CORR_SAT_EN
         sat   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (i_clear || consume) begin
            acc   <= '0;
            count <= '0;
            bit_q <= 1'b0;
`ifdef DCSK_CORR_SAT_EN
            sat   <= 1'b0;
`endif
         end else if (accept) begin
            acc   <= add_sum;
            count <= (state == ACCUM) ? count + CNT_W'(1) : CNT_W'(1);
            if (last) bit_q <= ~add_sum[ACC_W-1];
`ifdef DCSK_CORR_SAT_EN
            sat   <= ((state == ACCUM) && sat) || ovf;
`endif
         end
      end
   end

   assign o_ready = (state != DONE);
   assign o_valid = (state == DONE);
   assign o_sum   = acc;
   assign o_bit   = bit_q;

endmodule

// File: tb/tb_dcsk_correlator.sv
// Self-checking bench for dcsk_correlator: directed scenarios plus randomized
// traffic against a symbol-level reference model, on an 18-bit and a 16-bit accumulator.
module tb_dcsk_correlator;

   localparam int SF   = 4;
   localparam int WL   = 8;
   localparam int AW   = 18;
   localparam int AW16 = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic signed [15:0]    product;
   logic                  valid;
   logic                  clear;
   logic                  ready;

   logic                  ready_a, bit_a, valid_a, sat_a;
   logic signed [AW-1:0]  sum_a;
   logic                  ready_b, bit_b, valid_b, sat_b;
   logic signed [AW16-1:0] sum_b;

   int passed = 0;
   int total  = 0;

   // reference model: products of the symbol in flight and its completed result
   longint prods[$];
   bit     done;
   longint exp_sum[2];
   bit     exp_sat[2];

   always #5 clk = ~clk;

   dcsk_correlator #(.WORD_LEN(WL), .SPREAD_FACTOR(SF)) dut (
      .i_clk(clk), .i_arst_n(rst_n), .i_product(product), .i_valid(valid),
      .o_ready(ready_a), .i_clear(clear), .o_sum(sum_a), .o_bit(bit_a),
      .o_valid(valid_a), .i_ready(ready), .o_sat(sat_a)
   );

   dcsk_correlator #(.WORD_LEN(WL), .SPREAD_FACTOR(SF), .ACC_W(AW16)) dut16 (
      .i_clk(clk), .i_arst_n(rst_n), .i_product(product), .i_valid(valid),
      .o_ready(ready_b), .i_clear(clear), .o_sum(sum_b), .o_bit(bit_b),
      .o_valid(valid_b), .i_ready(ready), .o_sat(sat_b)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic longint wrap(input longint v, input int w);
      longint m;
      m = v & ((64'sd1 <<< w) - 1);
      if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
      return m;
   endfunction

   function automatic longint fold(input int w, output bit s);
      longint hi, lo, a;
      hi = (64'sd1 <<< (w - 1)) - 1;
      lo = -(64'sd1 <<< (w - 1));
      a  = 0;
      s  = 1'b0;
      foreach (prods[i]) begin
         a = a + prods[i];
`ifdef DCSK_CORR_SAT_EN
         if (a > hi) begin a = hi; s = 1'b1; end
         else if (a < lo) begin a = lo; s = 1'b1; end
`else
         a = wrap(a, w);
`endif
      end
      return a;
   endfunction

   task automatic compare_outputs();
      check("ready_a", longint'(ready_a), longint'(!done));
      check("valid_a", longint'(valid_a), longint'(done));
      check("ready_b", longint'(ready_b), longint'(!done));
      check("valid_b", longint'(valid_b), longint'(done));
      if (done) begin
         check("sum_a", sum_a, exp_sum[0]);
         check("bit_a", longint'(bit_a), longint'(exp_sum[0] >= 0));
         check("sat_a", longint'(sat_a), longint'(exp_sat[0]));
         check("sum_b", sum_b, exp_sum[1]);
         check("bit_b", longint'(bit_b), longint'(exp_sum[1] >= 0));
         check("sat_b", longint'(sat_b), longint'(exp_sat[1]));
      end
   endtask

   // compare, drive one cycle of inputs, advance model across the rising edge
   task automatic cyc(input bit v, input longint p, input bit rdy, input bit clr);
      compare_outputs();
      valid   = v;
      product = 16'(p);
      ready   = rdy;
      clear   = clr;
      @(posedge clk);
      if (clr) begin
         prods.delete();
         done = 1'b0;
      end else if (done) begin
         if (rdy) begin
            prods.delete();
            done = 1'b0;
         end
      end else if (v) begin
         prods.push_back(longint'($signed(16'(p))));
         if (prods.size() == SF) begin
            done       = 1'b1;
            exp_sum[0] = fold(AW, exp_sat[0]);
            exp_sum[1] = fold(AW16, exp_sat[1]);
         end
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      valid = 1'b0;
      clear = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_sum", sum_a, 0);
      check("rst_bit", longint'(bit_a), 0);
      check("rst_sat", longint'(sat_a), 0);
      check("rst_valid", longint'(valid_a), 0);
      check("rst_ready", longint'(ready_a), 1);
      check("rst_sum16", sum_b, 0);
      prods.delete();
      done = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic signed [15:0] r;
      longint p;
      rst_n   = 1'b0;
      product = '0;
      valid   = 1'b0;
      clear   = 1'b0;
      ready   = 1'b0;
      done    = 1'b0;
      #2;
      check("init_sum", sum_a, 0);
      check("init_bit", longint'(bit_a), 0);
      check("init_sat", longint'(sat_a), 0);
      check("init_valid", longint'(valid_a), 0);
      check("init_ready", longint'(ready_a), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // basic symbol
      cyc(1, 100, 0, 0); cyc(1, 200, 0, 0); cyc(1, -50, 0, 0); cyc(1, 10, 0, 0);
      check("basic_valid", longint'(valid_a), 1);
      check("basic_sum", sum_a, 260);
      check("basic_bit", longint'(bit_a), 1);

      // backpressure with offered products that must be ignored
      repeat (5) cyc(1, 999, 0, 0);
      check("bp_sum", sum_a, 260);
      check("bp_ready", longint'(ready_a), 0);
      cyc(0, 0, 1, 0);

      // negative symbol
      repeat (3) cyc(1, -16256, 0, 0);
      cyc(1, -16256, 0, 0);
      check("neg_sum", sum_a, -65024);
      check("neg_bit", longint'(bit_a), 0);
      check("neg_sat", longint'(sat_a), 0);
      cyc(0, 0, 1, 0);

      // abort mid-symbol, with a product offered alongside the clear
      cyc(1, 100, 0, 0); cyc(1, 200, 0, 0); cyc(1, 77, 0, 1);
      cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
      check("abort_sum", sum_a, 10);
      cyc(1, 5, 0, 1);
      check("clr_done_valid", longint'(valid_a), 0);

      // asynchronous reset mid-symbol
      cyc(1, 7, 0, 0); cyc(1, 8, 0, 0); cyc(1, 9, 0, 0);
      pulse_reset();
      repeat (4) cyc(1, 5, 0, 0);
      check("post_rst_sum", sum_a, 20);
      cyc(0, 0, 1, 0);

      // overflow on the 16-bit accumulator
      repeat (4) cyc(1, 16129, 0, 0);
`ifdef DCSK_CORR_SAT_EN
      check("sat16_sum", sum_b, 32767);
      check("sat16_flag", longint'(sat_b), 1);
      check("sat16_bit", longint'(bit_b), 1);
`else
      check("wrap16_sum", sum_b, -1020);
      check("wrap16_flag", longint'(sat_b), 0);
      check("wrap16_bit", longint'(bit_b), 0);
`endif
      cyc(0, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0)
            r = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
         else
            r = 16'($urandom);
         p = r;
         if ($urandom_range(0, 299) == 0) pulse_reset();
         cyc($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0,
             $urandom_range(0, 39) == 0);
      end
      compare_outputs();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
